// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared widths, field positions, reset PC and state codes for the prefetch stage
package if_prefetch_pkg;
  localparam int FIFO_DATA_W = 65;
  localparam int ADEL_BIT = 64;
  localparam int PC_MSB = 63;
  localparam int PC_LSB = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  typedef logic [FIFO_DATA_W-1:0] fifo_data_t;
  function automatic fifo_data_t pack_entry(input logic adel, input logic [31:0] pc, input logic [31:0] inst);
    return {adel, pc, inst};
  endfunction
endpackage

// File: rtl/if_small_fifo.sv
// if_small_fifo: small synchronous FIFO with clear
// Ports: clk, rst (async, active-high), clr (drop all entries), push/din, pop,
//        head (oldest entry, valid when count!=0), count (entries held)
module if_small_fifo #(
  parameter int W = 32,
  parameter int D = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  logic [W-1:0] mem [D];
  logic [PW-1:0] rp, wp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == D - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else if (clr) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push & ~clr) mem[wp] <= din;
  assign head = mem[rp];
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction prefetch feeding the instruction-buffer FIFO
// Ports: clk, rst (async, active-high); redirect/redirect_pc reload the fetch PC;
//        inst_req/inst_addr/inst_addr_ok issue requests, inst_data_ok/inst_rdata return
//        words in order; fifo_in {adel,pc,inst} with fifo_w_en, throttled by fifo_full
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output fifo_data_t       fifo_in,
  output logic             fifo_w_en,
  input  logic             fifo_full
);
  logic [31:0] pc, hold_addr, pend_pc;
  logic [0:0] state;
  logic req_hold, stale, credit, acc, acc_cancel, acc_live, kept, drop, mis_push;
  logic [1:0] live, cancel, rb_cnt, pend_cnt;
  fifo_data_t rb_head, rb_din;
  assign credit = 4'(live) + 4'(cancel) + 4'(rb_cnt) < 4'(MAX_OUT);
  assign inst_req = ~rst & (req_hold | (state == RUN & ~redirect & pc[1:0] == 2'b00 & credit));
  // a held request keeps its original address even after a redirect has moved pc
  assign inst_addr = req_hold ? hold_addr : pc;
  assign acc = inst_req & inst_addr_ok;
  assign acc_cancel = acc & (redirect | stale);
  assign acc_live = acc & ~acc_cancel;
  assign kept = inst_data_ok & cancel == 2'd0;
  assign drop = inst_data_ok & cancel != 2'd0;
  // the fault entry waits until every older word has left, keeping program order
  assign mis_push = state == RUN & pc[1:0] != 2'b00 & live == 2'd0 & rb_cnt == 2'd0 & ~redirect;
  assign rb_din = mis_push ? pack_entry(1'b1, pc, 32'h0) : pack_entry(1'b0, pend_pc, inst_rdata);
  assign fifo_w_en = rb_cnt != 2'd0 & ~fifo_full & ~redirect;
  assign fifo_in = rb_cnt != 2'd0 ? rb_head : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      hold_addr <= RESET_PC;
      state <= RUN;
      req_hold <= 1'b0;
      stale <= 1'b0;
      live <= 2'd0;
      cancel <= 2'd0;
    end else begin
      pc <= redirect ? redirect_pc : acc_live ? pc + 32'd4 : pc;
      state <= redirect ? RUN : mis_push ? HALT : state;
      req_hold <= inst_req & ~inst_addr_ok;
      stale <= inst_req & ~inst_addr_ok & (stale | redirect);
      hold_addr <= inst_addr;
      live <= redirect ? 2'd0 : live + 2'(acc_live) - 2'(kept);
      cancel <= redirect ? cancel - 2'(drop) + live - 2'(kept) + 2'(acc)
                         : cancel - 2'(drop) + 2'(acc_cancel);
    end
  if_small_fifo #(.W(32), .D(MAX_OUT), .CW(2)) u_pend (
    .clk(clk), .rst(rst), .clr(redirect), .push(acc_live), .pop(kept),
    .din(pc), .head(pend_pc), .count(pend_cnt)
  );
  if_small_fifo #(.W(FIFO_DATA_W), .D(MAX_OUT), .CW(2)) u_rb (
    .clk(clk), .rst(rst), .clr(redirect), .push(kept | mis_push), .pop(fifo_w_en),
    .din(rb_din), .head(rb_head), .count(rb_cnt)
  );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: randomized scoreboard bench for if_prefetch
module tb_if_prefetch;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  logic clk, rst, redirect, inst_req, inst_addr_ok, inst_data_ok, fifo_w_en, fifo_full;
  logic [31:0] redirect_pc, inst_addr, inst_rdata;
  logic [64:0] fifo_in;
  int checks, failures, ok_pct, dok_pct, full_pct, seg_writes, since_rd;
  bit halt_phase, prev_pend;
  logic [31:0] prev_addr, rpc;
  logic [64:0] sb[$];
  logic [31:0] mq[$];

  if_prefetch #(.RESET_PC(RST_PC), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .fifo_in(fifo_in), .fifo_w_en(fifo_w_en), .fifo_full(fifo_full)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // expected stream after a (re)start at pc: sequential words, or one fault entry
  task automatic push_seg(input logic [31:0] pc);
    logic [31:0] a;
    if (pc[1:0] != 2'b00) sb.push_back({1'b1, pc, 32'h0});
    else for (int i = 0; i < 64; i++) begin
      a = pc + 32'(4 * i);
      sb.push_back({1'b0, a, word(a)});
    end
  endtask

  task automatic cyc(input bit rd, input logic [31:0] pc);
    @(negedge clk);
    redirect = rd;
    redirect_pc = pc;
    fifo_full = $urandom_range(99) < full_pct;
    if (rd) begin
      sb.delete();
      push_seg(pc);
      seg_writes = 0;
    end
    #1;
    if (prev_pend) begin
      chk("hold_req", inst_req, 1);
      chk("hold_addr", inst_addr, prev_addr);
    end
    if (halt_phase) chk("halt_noreq", inst_req, 0);
    inst_addr_ok = $urandom_range(99) < ok_pct;
    inst_data_ok = mq.size() != 0 && $urandom_range(99) < dok_pct;
    if (inst_data_ok) inst_rdata = word(mq[0]);
    else inst_rdata = $urandom;
    #2;
    prev_pend = inst_req & ~inst_addr_ok;
    prev_addr = inst_addr;
    if (inst_req && inst_addr_ok) begin
      mq.push_back(inst_addr);
      chk("credit", mq.size() <= MAX_OUT, 1);
    end
    if (inst_data_ok) void'(mq.pop_front());
  endtask

  task automatic reset_checks();
    chk("rst_req", inst_req, 0);
    chk("rst_addr", inst_addr, RST_PC);
    chk("rst_wen", fifo_w_en, 0);
    chk("rst_fifo_in", fifo_in, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (fifo_full || redirect) chk("wen_blocked", fifo_w_en, 0);
        if (fifo_w_en) begin
          seg_writes++;
          if (sb.size() == 0) chk("unexpected_write", fifo_in, 0 - 1);
          else chk("fifo_entry", fifo_in, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; seg_writes = 0; halt_phase = 0; prev_pend = 0;
    rst = 1; redirect = 0; redirect_pc = 0; inst_addr_ok = 0; inst_data_ok = 0;
    inst_rdata = 0; fifo_full = 0; ok_pct = 100; dok_pct = 100; full_pct = 0;
    repeat (3) @(negedge clk);
    #3 reset_checks();
    push_seg(RST_PC);
    @(negedge clk) rst = 0;
    repeat (30) cyc(0, 0);
    chk("stream_rate", seg_writes >= 15, 1);

    cyc(1, 32'h0000_1000);
    full_pct = 100;
    repeat (12) cyc(0, 0);
    #1;
    chk("full_noreq", inst_req, 0);
    chk("full_nowrite", seg_writes, 0);
    chk("full_mem_idle", mq.size(), 0);
    full_pct = 0;
    repeat (15) cyc(0, 0);
    chk("full_drain", seg_writes >= MAX_OUT, 1);

    dok_pct = 0;
    repeat (3) cyc(0, 0);
    chk("two_outstanding", mq.size(), 2);
    dok_pct = 100;
    cyc(1, 32'h8000_0100);
    repeat (15) cyc(0, 0);
    chk("redirect_resume", seg_writes > 0, 1);

    ok_pct = 0;
    repeat (3) cyc(0, 0);
    chk("pend_req", inst_req, 1);
    cyc(1, 32'h8000_0400);
    repeat (2) cyc(0, 0);
    ok_pct = 100;
    repeat (15) cyc(0, 0);
    chk("held_resume", seg_writes > 0, 1);

    cyc(1, 32'h8000_0102);
    halt_phase = 1;
    repeat (20) cyc(0, 0);
    halt_phase = 0;
    chk("adel_single", seg_writes, 1);
    chk("adel_drained", sb.size(), 0);
    cyc(1, 32'h8000_0200);
    repeat (15) cyc(0, 0);
    chk("halt_resume", seg_writes > 0, 1);

    cyc(1, 32'hFFFF_FFF8);
    repeat (10) cyc(0, 0);
    chk("wrap_progress", seg_writes > 2, 1);

    repeat (5) cyc(0, 0);
    @(negedge clk);
    #2 rst = 1;
    #1 reset_checks();
    mq.delete(); sb.delete(); push_seg(RST_PC);
    prev_pend = 0; inst_addr_ok = 0; inst_data_ok = 0; redirect = 0;
    @(negedge clk) rst = 0;
    seg_writes = 0;
    repeat (20) cyc(0, 0);
    chk("restart", seg_writes > 0, 1);

    since_rd = 0;
    for (int k = 0; k < 480; k++) begin
      if (k % 40 == 0) begin
        ok_pct = $urandom_range(30, 100);
        dok_pct = $urandom_range(30, 100);
        full_pct = $urandom_range(0, 60);
      end
      if (since_rd >= 40 || $urandom_range(99) < 5) begin
        rpc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(9) == 0) rpc = rpc | 32'($urandom_range(1, 3));
        if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF4;
        since_rd = 0;
        cyc(1, rpc);
      end else begin
        since_rd++;
        cyc(0, 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
